sdram_req_arbiter: RTL and testbench
====================================

// Module: sdram_req_arbiter
// PURPOSE
//  Two-port arbiter and sequencer between user requesters and sdram_controller's user interface.
//  Port 0 is typically instruction prefetch and port 1 data/DMA.
//  The block grants one request at a time and drives the single-entry controller queue.
//  Read beats from the controller (BEATS per read, prefetch) are routed back to the granted port.
//  Write completion is tracked so that only one operation is ever outstanding.
// PARAMETERS
//  AW     23  address width, matches controller user_addr
//  DW     32  data width
//  BEATS  4   read beats returned per read command (controller prefetch depth)
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous, active-high reset
//  reqN_valid       in   1   request pending on port N (N=0,1); held until reqN_ready
//  reqN_ready       out  1   one-cycle accept pulse for port N
//  reqN_rw          in   1   1=write, 0=read
//  reqN_addr        in   AW  word address
//  reqN_wdata       in   DW  write data
//  reqN_step        in   1   prefetch step select, forwarded to controller
//  reqN_rvalid      out  1   read beat valid for port N
//  reqN_rdata       out  DW  read beat data for port N
//  reqN_rlast       out  1   high with the final (BEATS-th) beat
//  ctl_in_valid     out  1   to controller in_valid
//  ctl_rw           out  1   to controller rw
//  ctl_addr         out  AW  to controller user_addr
//  ctl_wdata        out  DW  to controller data_in
//  ctl_step         out  1   to controller prefetch_step
//  ctl_busy         in   1   from controller busy
//  ctl_out_valid    in   1   from controller out_valid
//  ctl_rdata        in   DW  from controller data_out
// BEHAVIOUR
//  - Reset values:
//    - state=IDLE; all *_ready, *_rvalid, *_rlast and ctl_in_valid are 0.
//    - ctl_rw/ctl_addr/ctl_wdata/ctl_step/rdata are 0.
//    - Grant pointer points at port 0.
//  - FSM states: IDLE -> ISSUE -> ACK -> {RD_DATA | WR_DONE} -> IDLE.
//  - IDLE: if ctl_busy=0 and any reqN_valid, select the winner.
//    - In the same cycle: reqW_ready=1 (combinational) and latch rw/addr/wdata/step/owner.
//    - Next state ISSUE.
//    - No grant while ctl_busy=1.
//  - ISSUE: ctl_in_valid=1 (registered, exactly one cycle) with the latched fields -> ACK.
//  - ACK: wait for ctl_busy=1 (the controller took the entry).
//    - Read -> RD_DATA; write -> WR_DONE.
//    - If ctl_busy does not rise within 1 cycle, stay in ACK; never reissue.
//  - RD_DATA: each ctl_out_valid increments beat_cnt (2 bits, log2 BEATS).
//    - Same cycle: owner rvalid=1 and rdata=ctl_rdata (combinational pass-through; other port rvalid=0).
//    - rlast=1 when beat_cnt==BEATS-1; beat_cnt wraps to 0; -> IDLE.
//  - WR_DONE: wait for ctl_busy=0 -> IDLE.
//    - No data is returned; reqN_rvalid stays 0.
//  - Simultaneous valid on both ports: priority per CONFIGURATION; the loser keeps valid and waits.
//  - New request arriving during RD_DATA/WR_DONE: not accepted until IDLE; no ready pulse.
//  - ctl_out_valid outside RD_DATA: ignored and not routed.
//  - Reset mid-operation: FSM returns to IDLE and beat_cnt=0.
//    - The controller shares rst, so no completion is awaited.
//  - Throughput: at most one command outstanding.
//    - Minimum IDLE-to-IDLE for a write is 4 cycles (IDLE, ISSUE, ACK, WR_DONE).
// CONFIGURATION
//  SDRAM_ARB_RR_EN defined: round-robin.
//    - With both ports valid, the port not granted last wins.
//    - The pointer updates on each grant.
//  SDRAM_ARB_RR_EN undefined: fixed priority, port 0 always wins; the pointer is unused.
// TESTING
//  1. Single read, port 0, addr=0x000100, step=0, controller returns 4 beats A0..A3 -> req0_ready 1 pulse;
//     ctl_in_valid 1 pulse with ctl_addr=0x000100, ctl_rw=0; req0_rvalid x4 with data A0..A3;
//     req0_rlast only on A3; req1_rvalid never.
//  2. Single write, port 1, addr=0x000400, wdata=0xDEADBEEF -> ctl_rw=1, ctl_wdata=0xDEADBEEF;
//     returns to IDLE after ctl_busy falls; no rvalid on either port.
//  3. Both ports valid with reads in the same cycle, fixed priority -> port 0 granted first;
//     port 1 granted only after port 0's 4th beat; beats routed to the correct port.
//  4. SDRAM_ARB_RR_EN, both ports continuously valid for 4 reads -> grant order 0,1,0,1.
//  5. ctl_busy held high for 10 cycles while req0_valid=1 -> no req0_ready and no ctl_in_valid;
//     grant the cycle after ctl_busy falls.
//  6. rst asserted after the 2nd read beat -> next cycle all outputs 0, state IDLE;
//     a fresh read after reset completes normally with 4 beats.

Source files
------------

// File: rtl/sdram_req_arbiter_if.sv
// sdram_req_arbiter_if: two requester ports plus the sdram controller user interface seen by the arbiter
interface sdram_req_arbiter_if #(
  parameter int AW = 23,
  parameter int DW = 32
);
  logic          req0_valid, req0_ready, req0_rw, req0_step, req0_rvalid, req0_rlast;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_ready, req1_rw, req1_step, req1_rvalid, req1_rlast;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          ctl_in_valid, ctl_rw, ctl_step, ctl_busy, ctl_out_valid;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_wdata, ctl_rdata;
  modport slave (
    input  req0_valid, req0_rw, req0_addr, req0_wdata, req0_step,
    output req0_ready, req0_rvalid, req0_rdata, req0_rlast,
    input  req1_valid, req1_rw, req1_addr, req1_wdata, req1_step,
    output req1_ready, req1_rvalid, req1_rdata, req1_rlast,
    output ctl_in_valid, ctl_rw, ctl_addr, ctl_wdata, ctl_step,
    input  ctl_busy, ctl_out_valid, ctl_rdata
  );
  modport master (
    output req0_valid, req0_rw, req0_addr, req0_wdata, req0_step,
    input  req0_ready, req0_rvalid, req0_rdata, req0_rlast,
    output req1_valid, req1_rw, req1_addr, req1_wdata, req1_step,
    input  req1_ready, req1_rvalid, req1_rdata, req1_rlast,
    input  ctl_in_valid, ctl_rw, ctl_addr, ctl_wdata, ctl_step,
    output ctl_busy, ctl_out_valid, ctl_rdata
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: two-port arbiter/sequencer for the sdram controller queue; define SDRAM_ARB_RR_EN for round-robin, else port 0 has fixed priority
module sdram_req_arbiter #(
  parameter int AW    = 23,
  parameter int DW    = 32,
  parameter int BEATS = 4
) (
  input logic              clk,
  input logic              rst,
  sdram_req_arbiter_if.slave bus
);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, ACK = 3'd2, RD_DATA = 3'd3, WR_DONE = 3'd4;
  logic [2:0]    state, state_nx;
  logic [BW-1:0] beat_cnt;
  logic          owner, win, grant, rd_beat, beat_last, rv0, rv1;
`ifdef SDRAM_ARB_RR_EN
  logic ptr;
  assign win = (bus.req0_valid && bus.req1_valid) ? ptr : !bus.req0_valid;
  // pointer holds the port favoured on the next contested grant: the one not granted last
  always_ff @(posedge clk)
    if (rst) ptr <= 1'b0;
    else if (grant) ptr <= !win;
`else
  assign win = !bus.req0_valid;
`endif
  assign grant     = state == IDLE && !bus.ctl_busy && (bus.req0_valid || bus.req1_valid);
  assign rd_beat   = state == RD_DATA && bus.ctl_out_valid;
  assign beat_last = beat_cnt == BW'(BEATS - 1);
  assign rv0       = rd_beat && !owner;
  assign rv1       = rd_beat && owner;
  assign bus.req0_ready  = grant && !win;
  assign bus.req1_ready  = grant && win;
  assign bus.req0_rvalid = rv0;
  assign bus.req1_rvalid = rv1;
  assign bus.req0_rlast  = rv0 && beat_last;
  assign bus.req1_rlast  = rv1 && beat_last;
  assign bus.req0_rdata  = rv0 ? bus.ctl_rdata : {DW{1'b0}};
  assign bus.req1_rdata  = rv1 ? bus.ctl_rdata : {DW{1'b0}};
  // one command in flight: grant, issue once, wait for the controller to take it, then drain
  always_comb
    state_nx = state == IDLE    ? (grant ? ISSUE : IDLE) :
               state == ISSUE   ? ACK :
               state == ACK     ? (bus.ctl_busy ? (bus.ctl_rw ? WR_DONE : RD_DATA) : ACK) :
               state == RD_DATA ? ((rd_beat && beat_last) ? IDLE : RD_DATA) :
               state == WR_DONE ? (bus.ctl_busy ? WR_DONE : IDLE) : IDLE;
  // latch the winner's command, pulse in_valid during ISSUE, count read beats
  always_ff @(posedge clk)
    if (rst) begin
      state            <= IDLE;
      owner            <= 1'b0;
      beat_cnt         <= '0;
      bus.ctl_in_valid <= 1'b0;
      bus.ctl_rw       <= 1'b0;
      bus.ctl_addr     <= {AW{1'b0}};
      bus.ctl_wdata    <= {DW{1'b0}};
      bus.ctl_step     <= 1'b0;
    end else begin
      state            <= state_nx;
      bus.ctl_in_valid <= grant;
      if (grant) begin
        owner         <= win;
        bus.ctl_rw    <= win ? bus.req1_rw    : bus.req0_rw;
        bus.ctl_addr  <= win ? bus.req1_addr  : bus.req0_addr;
        bus.ctl_wdata <= win ? bus.req1_wdata : bus.req0_wdata;
        bus.ctl_step  <= win ? bus.req1_step  : bus.req0_step;
      end
      if (rd_beat) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
    end
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb_sdram_req_arbiter: directed scoreboard bench with a cycle-level sdram controller model
`timescale 1ns/1ps
module tb_sdram_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sdram_req_arbiter_if #(.AW(23), .DW(32)) bus ();
  sdram_req_arbiter #(.AW(23), .DW(32), .BEATS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, fails = 0, cyc = 0, beats0 = 0;
  logic [32:0] rd_q0[$], rd_q1[$];
  logic [56:0] cmd_q[$];
  int rdy_port_q[$], rdy_cyc_q[$];
  logic force_busy = 1'b0;
  int ack_delay = 0;
  int mp, ep, ec;
  logic [32:0] eb;
  logic [56:0] ecmd;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin : ctl_model
    int st, cnt, beat;
    logic rw;
    logic [15:0] a;
    st = 0; cnt = 0; beat = 0; rw = 1'b0; a = '0;
    bus.ctl_busy = 1'b0; bus.ctl_out_valid = 1'b0; bus.ctl_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.ctl_out_valid = 1'b0;
      bus.ctl_rdata = '0;
      if (rst) begin
        st = 0; bus.ctl_busy = force_busy;
      end else if (st == 0) begin
        bus.ctl_busy = force_busy;
        if (bus.ctl_in_valid) begin
          rw = bus.ctl_rw; a = bus.ctl_addr[15:0];
          if (ack_delay == 0) begin bus.ctl_busy = 1'b1; st = 2; cnt = 1; end
          else begin st = 1; cnt = ack_delay; end
        end
      end else if (st == 1) begin
        cnt--;
        if (cnt == 0) begin bus.ctl_busy = 1'b1; st = 2; cnt = 1; end
      end else if (st == 2) begin
        if (cnt > 0) cnt--;
        else if (rw) begin st = 4; cnt = 2; end
        else begin st = 3; beat = 0; end
      end else if (st == 4) begin
        if (cnt > 0) cnt--;
        else begin bus.ctl_busy = 1'b0; st = 0; end
      end else if (st == 5) begin
        bus.ctl_busy = 1'b0; st = 0;
      end
      if (st == 3) begin
        bus.ctl_out_valid = 1'b1;
        bus.ctl_rdata = {a, 16'(16'hA000 + beat)};
        beat++;
        if (beat == 4) st = 5;
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    if (bus.req0_ready || bus.req1_ready) begin
      mp = bus.req1_ready ? 1 : 0;
      checks++;
      if (bus.req0_ready && bus.req1_ready) begin
        fails++; $display("FAIL ready_onehot: req0_ready=1 req1_ready=1, required only one");
      end else if (rdy_port_q.size() == 0) begin
        fails++; $display("FAIL ready_unexpected: port %0d ready at cycle %0d, required no grant", mp, cyc);
      end else begin
        ep = rdy_port_q.pop_front(); ec = rdy_cyc_q.pop_front();
        if (ep != mp || (ec >= 0 && ec != cyc)) begin
          fails++; $display("FAIL grant: port %0d at cycle %0d, required port %0d at cycle %0d", mp, cyc, ep, ec);
        end
      end
    end
    if (bus.ctl_in_valid) begin
      checks++;
      if (cmd_q.size() == 0) begin
        fails++; $display("FAIL issue_unexpected: ctl_in_valid=1 addr=%h, required no issue", bus.ctl_addr);
      end else begin
        ecmd = cmd_q.pop_front();
        if ({bus.ctl_rw, bus.ctl_step, bus.ctl_addr, bus.ctl_wdata} != ecmd) begin
          fails++; $display("FAIL issue: rw/step/addr/wdata=%h, required %h", {bus.ctl_rw, bus.ctl_step, bus.ctl_addr, bus.ctl_wdata}, ecmd);
        end
      end
    end
    if (bus.req0_rvalid) begin
      checks++; beats0++;
      if (rd_q0.size() == 0) begin
        fails++; $display("FAIL beat0_unexpected: last=%b data=%h, required no beat", bus.req0_rlast, bus.req0_rdata);
      end else begin
        eb = rd_q0.pop_front();
        if ({bus.req0_rlast, bus.req0_rdata} != eb) begin
          fails++; $display("FAIL beat0: last=%b data=%h, required last=%b data=%h", bus.req0_rlast, bus.req0_rdata, eb[32], eb[31:0]);
        end
      end
    end
    if (bus.req1_rvalid) begin
      checks++;
      if (rd_q1.size() == 0) begin
        fails++; $display("FAIL beat1_unexpected: last=%b data=%h, required no beat", bus.req1_rlast, bus.req1_rdata);
      end else begin
        eb = rd_q1.pop_front();
        if ({bus.req1_rlast, bus.req1_rdata} != eb) begin
          fails++; $display("FAIL beat1: last=%b data=%h, required last=%b data=%h", bus.req1_rlast, bus.req1_rdata, eb[32], eb[31:0]);
        end
      end
    end
  end
  task automatic exp_rd(input int p, input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++)
      if (p == 0) rd_q0.push_back({i == 3, a, 16'(16'hA000 + i)});
      else rd_q1.push_back({i == 3, a, 16'(16'hA000 + i)});
  endtask
  task automatic exp_cmd(input logic rw, input logic st, input logic [22:0] a, input logic [31:0] d);
    cmd_q.push_back({rw, st, a, d});
  endtask
  task automatic exp_rdy(input int p, input int c);
    rdy_port_q.push_back(p); rdy_cyc_q.push_back(c);
  endtask
  task automatic drive(input int p, input logic rw, input logic [22:0] a, input logic [31:0] d, input logic st);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (p == 0) begin
      bus.req0_valid = 1'b1; bus.req0_rw = rw; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_step = st;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_rw = rw; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_step = st;
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = p == 0 ? bus.req0_ready : bus.req1_ready;
    end
    if (!got) begin
      checks++; fails++; $display("FAIL ready_timeout: port %0d ready=0, required 1", p);
    end
    @(posedge clk); #1;
    if (p == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask
  task automatic settle();
    int n;
    n = 0;
    while (rd_q0.size() + rd_q1.size() + cmd_q.size() + rdy_port_q.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 300) begin
      fails++;
      $display("FAIL settle: %0d expectations outstanding, required 0", rd_q0.size() + rd_q1.size() + cmd_q.size() + rdy_port_q.size());
    end
    repeat (8) @(negedge clk);
  endtask
  task automatic check_reset(input string tag);
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.req0_rvalid, bus.req1_rvalid, bus.req0_rlast, bus.req1_rlast,
         bus.req0_rdata, bus.req1_rdata, bus.ctl_in_valid, bus.ctl_rw, bus.ctl_addr, bus.ctl_wdata, bus.ctl_step} != 0) begin
      fails++;
      $display("FAIL %s: outputs=%h, required all zero", tag,
        {bus.req0_ready, bus.req1_ready, bus.req0_rvalid, bus.req1_rvalid, bus.req0_rlast, bus.req1_rlast,
         bus.req0_rdata, bus.req1_rdata, bus.ctl_in_valid, bus.ctl_rw, bus.ctl_addr, bus.ctl_wdata, bus.ctl_step});
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int b, n;
    bus.req0_valid = 1'b0; bus.req0_rw = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_step = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_rw = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_step = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_state");
    @(posedge clk); #1 rst = 1'b0;
    exp_rdy(0, -1); exp_cmd(1'b0, 1'b0, 23'h000100, 32'h0); exp_rd(0, 16'h0100, 4);
    drive(0, 1'b0, 23'h000100, 32'h0, 1'b0);
    settle();
    ack_delay = 2;
    exp_rdy(1, -1); exp_cmd(1'b1, 1'b0, 23'h000400, 32'hDEADBEEF);
    drive(1, 1'b1, 23'h000400, 32'hDEADBEEF, 1'b0);
    settle();
    ack_delay = 0;
    exp_rdy(0, -1); exp_rdy(1, -1);
    exp_cmd(1'b0, 1'b0, 23'h000200, 32'h0); exp_cmd(1'b0, 1'b1, 23'h000300, 32'h0);
    exp_rd(0, 16'h0200, 4); exp_rd(1, 16'h0300, 4);
    fork
      drive(0, 1'b0, 23'h000200, 32'h0, 1'b0);
      drive(1, 1'b0, 23'h000300, 32'h0, 1'b1);
    join
    settle();
`ifdef SDRAM_ARB_RR_EN
    exp_rdy(0, -1); exp_rdy(1, -1); exp_rdy(0, -1); exp_rdy(1, -1);
    exp_cmd(1'b0, 1'b1, 23'h000010, 32'h0); exp_cmd(1'b0, 1'b0, 23'h000020, 32'h0);
    exp_cmd(1'b0, 1'b1, 23'h000011, 32'h0); exp_cmd(1'b0, 1'b0, 23'h000021, 32'h0);
`else
    exp_rdy(0, -1); exp_rdy(0, -1); exp_rdy(1, -1); exp_rdy(1, -1);
    exp_cmd(1'b0, 1'b1, 23'h000010, 32'h0); exp_cmd(1'b0, 1'b1, 23'h000011, 32'h0);
    exp_cmd(1'b0, 1'b0, 23'h000020, 32'h0); exp_cmd(1'b0, 1'b0, 23'h000021, 32'h0);
`endif
    exp_rd(0, 16'h0010, 4); exp_rd(0, 16'h0011, 4); exp_rd(1, 16'h0020, 4); exp_rd(1, 16'h0021, 4);
    fork
      begin drive(0, 1'b0, 23'h000010, 32'h0, 1'b1); drive(0, 1'b0, 23'h000011, 32'h0, 1'b1); end
      begin drive(1, 1'b0, 23'h000020, 32'h0, 1'b0); drive(1, 1'b0, 23'h000021, 32'h0, 1'b0); end
    join
    settle();
    @(negedge clk) force_busy = 1'b1;
    repeat (2) @(negedge clk);
    exp_cmd(1'b0, 1'b0, 23'h000500, 32'h0); exp_rd(0, 16'h0500, 4);
    fork
      drive(0, 1'b0, 23'h000500, 32'h0, 1'b0);
      begin
        repeat (10) @(negedge clk);
        exp_rdy(0, cyc + 1);
        force_busy = 1'b0;
      end
    join
    settle();
    exp_rdy(0, -1); exp_cmd(1'b0, 1'b0, 23'h000600, 32'h0); exp_rd(0, 16'h0600, 2);
    b = beats0; n = 0;
    fork
      drive(0, 1'b0, 23'h000600, 32'h0, 1'b0);
      begin
        while (beats0 < b + 2 && n < 300) begin @(negedge clk); #2; n++; end
        checks++;
        if (n >= 300) begin fails++; $display("FAIL beat_wait: %0d beats seen, required 2", beats0 - b); end
        rst = 1'b1;
      end
    join
    @(negedge clk);
    check_reset("reset_mid_read");
    @(posedge clk); #1 rst = 1'b0;
    settle();
    exp_rdy(0, -1); exp_cmd(1'b0, 1'b0, 23'h000700, 32'h0); exp_rd(0, 16'h0700, 4);
    drive(0, 1'b0, 23'h000700, 32'h0, 1'b0);
    settle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
